// File: rtl/fc7_rm_reader.sv
// fc7_rm_reader: streams a run of consecutive words out of port B of the fc7
// result RAM onto a valid/ready interface. Reads are only issued while the
// count of words in flight plus words buffered stays under FIFO_DEPTH, so the
// output FIFO can always absorb every word the RAM returns.
module fc7_rm_reader #(
    parameter int ADDR_WIDTH   = 11,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] addrb,
    input  logic [DATA_WIDTH-1:0] doutb,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0]    DEPTH_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_WORD  = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    state_t state, state_d;

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
    logic                  zero_done_q, zero_done_d;

    logic                  issue;
    logic [ADDR_WIDTH-1:0] issue_addr;
    logic                  issue_last;

    // The valid/last bits of a read travel beside addrb, then through a
    // READ_LATENCY-deep pipe so they line up with doutb.
    logic                    issued_v;
    logic                    issued_last;
    logic [READ_LATENCY-1:0] pipe_v;
    logic [READ_LATENCY-1:0] pipe_last;

    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_last;
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W-1:0]      outstanding;

    logic push, pop, credit_ok;

    assign push      = pipe_v[READ_LATENCY-1];
    assign m_valid   = (fifo_count != '0);
    assign pop       = m_valid & m_ready;
    // A slot freed by this cycle's handshake can be reused by this cycle's issue.
    assign credit_ok = (outstanding < DEPTH_CNT) | pop;
    assign m_data    = fifo_data[rd_ptr];
    assign m_last    = m_valid & fifo_last[rd_ptr];
    assign busy      = (state != IDLE);

    // Next-state, read issue and done decode; the first read goes out on the
    // same edge that accepts start.
    always_comb begin
        state_d     = state;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        zero_done_d = 1'b0;
        issue       = 1'b0;
        issue_addr  = addr_q;
        issue_last  = 1'b0;
        done        = zero_done_q;
        case (state)
            IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        zero_done_d = 1'b1;
                    end else begin
                        issue       = 1'b1;
                        issue_addr  = base_addr;
                        issue_last  = (length == ONE_WORD);
                        addr_d      = base_addr + 1'b1;
                        remaining_d = length - 1'b1;
                        state_d     = (length == ONE_WORD) ? DRAIN : ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (credit_ok) begin
                    issue       = 1'b1;
                    issue_addr  = addr_q;
                    issue_last  = (remaining_q == ONE_WORD);
                    addr_d      = addr_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == ONE_WORD) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && m_last) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, read address counter and remaining-word count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            zero_done_q <= 1'b0;
        end else begin
            state       <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            zero_done_q <= zero_done_d;
        end
    end

    // Registered RAM address plus the in-flight tracking pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            addrb       <= '0;
            issued_v    <= 1'b0;
            issued_last <= 1'b0;
            pipe_v      <= '0;
            pipe_last   <= '0;
        end else begin
            if (issue) begin
                addrb <= issue_addr;
            end
            issued_v     <= issue;
            issued_last  <= issue & issue_last;
            pipe_v[0]    <= issued_v;
            pipe_last[0] <= issued_last;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_v[i]    <= pipe_v[i-1];
                pipe_last[i] <= pipe_last[i-1];
            end
        end
    end

    // Output FIFO storage, pointers, occupancy and credit accounting.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            outstanding <= '0;
            fifo_last   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= doutb;
                fifo_last[wr_ptr] <= pipe_last[READ_LATENCY-1];
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            case ({issue, pop})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

endmodule

// File: tb/tb_fc7_rm_reader.sv
// Testbench for fc7_rm_reader: a 2-cycle RAM model feeds the DUT, and a
// transfer-level model (expected word queue built from RAM contents when a
// start is accepted) is compared against the outputs every cycle.
module tb_fc7_rm_reader;

    localparam int AW        = 11;
    localparam int DW        = 32;
    localparam int RL        = 2;
    localparam int FD        = 4;
    localparam int RAM_WORDS = 1 << AW;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          start     = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length    = '0;
    logic          busy;
    logic          done;
    logic [AW-1:0] addrb;
    logic [DW-1:0] doutb;
    logic          m_valid;
    logic          m_ready   = 1'b1;
    logic [DW-1:0] m_data;
    logic          m_last;

    int checks     = 0;
    int errors     = 0;
    int ready_mode = 0;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } word_t;

    word_t         exp_q[$];
    logic [DW-1:0] got_q[$];
    logic          model_busy  = 1'b0;
    logic          zero_pend   = 1'b0;
    logic          in_reset    = 1'b1;
    logic          prev_stall  = 1'b0;
    logic [DW-1:0] prev_data   = '0;
    logic          prev_last   = 1'b0;
    int            since_start = -1;

    logic [DW-1:0] ram [RAM_WORDS];
    logic [DW-1:0] ram_r1;

    always #5 clk = ~clk;

    fc7_rm_reader #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .READ_LATENCY(RL),
        .FIFO_DEPTH  (FD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base_addr(base_addr),
        .length   (length),
        .busy     (busy),
        .done     (done),
        .addrb    (addrb),
        .doutb    (doutb),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last)
    );

    // RAM port B: address sampled on one edge, data presented on the next.
    always @(posedge clk) begin
        ram_r1 <= ram[addrb];
        doutb  <= ram_r1;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison against the transfer model, then model update for
    // the coming edge.
    always @(negedge clk) begin : compare
        logic hs;
        logic last_hs;
        logic was_idle;
        hs      = m_valid && m_ready;
        last_hs = 1'b0;
        if (in_reset) begin
            checkOutput("rst_busy", busy, 1'b0);
            checkOutput("rst_done", done, 1'b0);
            checkOutput("rst_m_valid", m_valid, 1'b0);
            checkOutput("rst_m_last", m_last, 1'b0);
            checkOutput("rst_m_data", m_data, '0);
            checkOutput("rst_addrb", addrb, '0);
        end else begin
            if (prev_stall) begin
                checkOutput("hold_valid", m_valid, 1'b1);
                checkOutput("hold_data", m_data, prev_data);
                checkOutput("hold_last", m_last, prev_last);
            end
            if (exp_q.size() == 0) begin
                checkOutput("no_unexpected_valid", m_valid, 1'b0);
            end
            checkOutput("busy", busy, model_busy);
            last_hs = hs && (exp_q.size() != 0) && exp_q[0].last;
            checkOutput("done", done, zero_pend || last_hs);
            if (hs && exp_q.size() != 0) begin
                checkOutput("m_data", m_data, exp_q[0].data);
                checkOutput("m_last", m_last, exp_q[0].last);
                got_q.push_back(m_data);
                void'(exp_q.pop_front());
            end
            if (since_start >= 0) begin
                since_start++;
                if (m_valid && since_start < 4) begin
                    checkOutput("first_valid_early", since_start, 4);
                    since_start = -1;
                end else if (since_start == 4) begin
                    checkOutput("first_valid_T+4", m_valid, 1'b1);
                    since_start = -1;
                end
            end
        end

        was_idle  = !model_busy;
        zero_pend = 1'b0;
        if (rst) begin
            exp_q.delete();
            model_busy  = 1'b0;
            since_start = -1;
            prev_stall  = 1'b0;
        end else begin
            if (last_hs) begin
                model_busy = 1'b0;
            end
            if (was_idle && start) begin
                if (length == '0) begin
                    zero_pend = 1'b1;
                end else begin
                    for (int i = 0; i < int'(length); i++) begin
                        word_t w;
                        w.data = ram[(int'(base_addr) + i) % RAM_WORDS];
                        w.last = (i == int'(length) - 1);
                        exp_q.push_back(w);
                    end
                    model_busy  = 1'b1;
                    since_start = 0;
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
        in_reset = rst;
    end

    // Downstream ready generator: 0 always, 1 fixed 1,0,0,1 pattern,
    // 2 coin flip, 3 mostly ready.
    initial begin : ready_gen
        logic [3:0] pat;
        int idx;
        pat = 4'b1001;
        idx = 0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = pat[idx % 4];
                2:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = ($urandom_range(0, 3) != 0);
            endcase
            idx++;
        end
    end

    task automatic pulseStart(input logic [AW-1:0] b, input int len);
        start     = 1'b1;
        base_addr = b;
        length    = (AW + 1)'(len);
        @(posedge clk);
        #1;
        start     = 1'b0;
        base_addr = AW'($urandom);
        length    = (AW + 1)'($urandom);
    endtask

    task automatic waitDone(input int limit, output int lat);
        lat = -1;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) begin
            checkOutput("done_timeout", done, 1'b1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [AW-1:0] b, input int len,
                                 input int mode, input int limit, output int lat);
        ready_mode = mode;
        got_q.delete();
        pulseStart(b, len);
        waitDone(limit, lat);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        int            lat;
        int            len;
        int            mode;
        logic [AW-1:0] b;
        logic [AW-1:0] wrap_addr [4];

        for (int i = 0; i < RAM_WORDS; i++) begin
            ram[i] = $urandom;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] basic stream");
        applyStimulus(11'h010, 8, 0, 100, lat);
        checkOutput("basic_done_latency", lat, 11);
        checkOutput("basic_count", got_q.size(), 8);
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            checkOutput("basic_word", got_q[i], ram[16 + i]);
        end
        checkOutput("basic_busy_after", busy, 1'b0);

        $display("[TB] backpressure");
        applyStimulus(11'h040, 16, 1, 400, lat);
        checkOutput("bp_pattern_count", got_q.size(), 16);
        applyStimulus(11'h0A0, 16, 2, 400, lat);
        checkOutput("bp_random_count", got_q.size(), 16);
        for (int i = 0; i < 16 && i < got_q.size(); i++) begin
            checkOutput("bp_random_word", got_q[i], ram[160 + i]);
        end

        $display("[TB] wrap and full span");
        wrap_addr[0] = 11'h7FE;
        wrap_addr[1] = 11'h7FF;
        wrap_addr[2] = 11'h000;
        wrap_addr[3] = 11'h001;
        applyStimulus(11'h7FE, 4, 3, 100, lat);
        checkOutput("wrap_count", got_q.size(), 4);
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            checkOutput("wrap_word", got_q[i], ram[wrap_addr[i]]);
        end
        applyStimulus(11'h123, 2048, 2, 20000, lat);
        checkOutput("full_span_count", got_q.size(), 2048);

        $display("[TB] zero length and ignored start");
        applyStimulus(11'h055, 0, 0, 20, lat);
        checkOutput("zero_done_latency", lat, 1);
        checkOutput("zero_count", got_q.size(), 0);
        ready_mode = 3;
        got_q.delete();
        pulseStart(11'h200, 10);
        pulseStart(11'h555, 3);
        waitDone(200, lat);
        checkOutput("ignored_start_count", got_q.size(), 10);
        for (int i = 0; i < 10 && i < got_q.size(); i++) begin
            checkOutput("ignored_start_word", got_q[i], ram[512 + i]);
        end
        repeat (20) @(posedge clk);
        #1;

        $display("[TB] reset mid-transfer");
        ready_mode = 0;
        got_q.delete();
        pulseStart(11'h300, 10);
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            #1;
            if (got_q.size() >= 3) break;
        end
        checkOutput("pre_reset_count", got_q.size(), 3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        applyStimulus(11'h100, 2, 0, 50, lat);
        checkOutput("post_reset_count", got_q.size(), 2);
        for (int i = 0; i < 2 && i < got_q.size(); i++) begin
            checkOutput("post_reset_word", got_q[i], ram[256 + i]);
        end

        $display("[TB] random back-to-back transfers");
        repeat (12) begin
            b    = AW'($urandom);
            len  = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 40));
            mode = int'($urandom_range(0, 3));
            applyStimulus(b, len, mode, len * 8 + 50, lat);
            checkOutput("random_count", got_q.size(), len);
        end

        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
